// File: rtl/datapath_pipe_if.sv
// Control/data bundle between an issuing agent and datapath_pipe.
// Latency: none (wires only).
// Backpressure: none; the datapath accepts an op every cycle that CTRVALID is high.
interface datapath_pipe_if #(
   parameter int WIDTH = 16,
   parameter int REGS  = 8
);
   localparam int AW = $clog2(REGS);
   localparam int CW = 3*AW + 7;

   logic [CW-1:0]    CTRWRD;
   logic             CTRVALID;
   logic [WIDTH-1:0] Cin;
   logic [WIDTH-1:0] Din;
   logic [WIDTH-1:0] Dout;
   logic [WIDTH-1:0] Adrout;
   logic             WBVALID;
   logic             V;
   logic             C;
   logic             N;
   logic             Z;

   // The agent that issues control words and supplies Cin/Din.
   modport master (
      output CTRWRD, CTRVALID, Cin, Din,
      input  Dout, Adrout, WBVALID, V, C, N, Z
   );

   // The datapath itself.
   modport slave (
      input  CTRWRD, CTRVALID, Cin, Din,
      output Dout, Adrout, WBVALID, V, C, N, Z
   );
endinterface

// File: rtl/datapath_pipe.sv
// Two-stage register-file datapath: operand fetch, then ALU execute and writeback.
// Latency: issue at edge k, register write and flags at edge k+1; one op per cycle.
// Backpressure: none; optional forwarding when DATAPATH_PIPE_FWD_EN is defined.
module datapath_pipe #(
   parameter int WIDTH = 16,
   parameter int REGS  = 8
) (
   input logic           CLK,
   input logic           RESET,
   datapath_pipe_if.slave bus
);
   localparam int AW = $clog2(REGS);
   localparam int CW = 3*AW + 7;

   // Control word fields, MSB first: {DA, AA, BA, MB, FS, MD, RW}.
   logic [AW-1:0] dec_da, dec_aa, dec_ba;
   logic          dec_mb, dec_md, dec_rw;
   logic [3:0]    dec_fs;

   assign {dec_da, dec_aa, dec_ba, dec_mb, dec_fs, dec_md, dec_rw} = bus.CTRWRD[CW-1:0];

   logic [WIDTH-1:0] regs [REGS];

   // Stage-1 (execute) state.
   logic             s1_vld;
   logic [WIDTH-1:0] s1_a, s1_b;
   logic [AW-1:0]    s1_da;
   logic [3:0]       s1_fs;
   logic             s1_md, s1_rw;

   logic             wb_vld;
   logic             flg_v, flg_c, flg_n, flg_z;

   // ALU intermediate values.
   logic [WIDTH-1:0] add_y;
   logic             add_ci;
   logic [WIDTH:0]   add_sum;
   logic [WIDTH-1:0] alu_f;
   logic             alu_c, alu_v;
   logic [WIDTH-1:0] wb_dat;
   logic             wr_en;

   // Operands as captured at issue.
   logic [WIDTH-1:0] rd_a, rd_b;

   // Second adder input and carry-in for the arithmetic group (FS 0-7).
   always_comb begin
      add_y  = '0;
      add_ci = 1'b0;
      case (s1_fs[2:0])
         3'd1:    add_ci = 1'b1;
         3'd2:    add_y  = s1_b;
         3'd3:    begin add_y = s1_b;  add_ci = 1'b1; end
         3'd4:    add_y  = ~s1_b;
         3'd5:    begin add_y = ~s1_b; add_ci = 1'b1; end
         3'd6:    add_y  = '1;
         default: begin add_y = '0;    add_ci = 1'b0; end
      endcase
   end

   assign add_sum = {1'b0, s1_a} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_ci};

   // Function result and carry/overflow; logic and shift ops override the adder.
   always_comb begin
      alu_f = add_sum[WIDTH-1:0];
      alu_c = add_sum[WIDTH];
      alu_v = (s1_a[WIDTH-1] == add_y[WIDTH-1]) && (alu_f[WIDTH-1] != s1_a[WIDTH-1]);
      if (s1_fs[3]) begin
         alu_c = 1'b0;
         alu_v = 1'b0;
         case (s1_fs[2:0])
            3'd0:    alu_f = s1_a & s1_b;
            3'd1:    alu_f = s1_a | s1_b;
            3'd2:    alu_f = s1_a ^ s1_b;
            3'd3:    alu_f = ~s1_a;
            3'd4:    alu_f = s1_b;
            3'd5:    begin alu_f = {1'b0, s1_b[WIDTH-1:1]}; alu_c = s1_b[0]; end
            3'd6:    begin alu_f = {s1_b[WIDTH-2:0], 1'b0}; alu_c = s1_b[WIDTH-1]; end
            default: alu_f = '0;
         endcase
      end
   end

   assign wb_dat = s1_md ? bus.Din : alu_f;
   assign wr_en  = s1_vld && s1_rw;

`ifdef DATAPATH_PIPE_FWD_EN
   // Bypass the executing op's writeback value into a dependent issue; Cin is never bypassed.
   always_comb begin
      rd_a = (wr_en && (s1_da == dec_aa)) ? wb_dat : regs[dec_aa];
      rd_b = regs[dec_ba];
      if (dec_mb)
         rd_b = bus.Cin;
      else if (wr_en && (s1_da == dec_ba))
         rd_b = wb_dat;
   end
`else
   // Operands come from the register file as it stands before this edge's write.
   always_comb begin
      rd_a = regs[dec_aa];
      rd_b = dec_mb ? bus.Cin : regs[dec_ba];
   end
`endif

   // Register file: written only by a valid executing op with RW set.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < REGS; i++)
            regs[i] <= '0;
      end else if (wr_en) begin
         regs[s1_da] <= wb_dat;
      end
   end

   // Issue stage: capture operands and control; idle cycles leave operands held.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         s1_vld <= 1'b0;
         s1_a   <= '0;
         s1_b   <= '0;
         s1_da  <= '0;
         s1_fs  <= '0;
         s1_md  <= 1'b0;
         s1_rw  <= 1'b0;
      end else begin
         s1_vld <= bus.CTRVALID;
         if (bus.CTRVALID) begin
            s1_a  <= rd_a;
            s1_b  <= rd_b;
            s1_da <= dec_da;
            s1_fs <= dec_fs;
            s1_md <= dec_md;
            s1_rw <= dec_rw;
         end
      end
   end

   // Writeback pulse and status flags; flags track only ALU results (MD=0).
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         wb_vld <= 1'b0;
         flg_v  <= 1'b0;
         flg_c  <= 1'b0;
         flg_n  <= 1'b0;
         flg_z  <= 1'b0;
      end else begin
         wb_vld <= wr_en;
         if (s1_vld && !s1_md) begin
            flg_v <= alu_v;
            flg_c <= alu_c;
            flg_n <= alu_f[WIDTH-1];
            flg_z <= (alu_f == '0);
         end
      end
   end

   assign bus.Adrout  = s1_a;
   assign bus.Dout    = s1_b;
   assign bus.WBVALID = wb_vld;
   assign bus.V       = flg_v;
   assign bus.C       = flg_c;
   assign bus.N       = flg_n;
   assign bus.Z       = flg_z;
endmodule

// File: doc/datapath_pipe.md
DATAPATH_PIPE -- requirements
Module: datapath_pipe

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits (legal range WIDTH >= 4).
REQ-002 Parameter REGS, default 8, register-file depth (power of two, >= 2); AW = log2(REGS).
REQ-003 Derived width CW = 3*AW + 7; the default configuration gives CW = 16.
REQ-004 CLK  input  1  single clock; all state changes on the rising edge.
REQ-005 RESET  input  1  asynchronous, active-high reset.
REQ-006 CTRWRD  input  CW  control word {DA[AW], AA[AW], BA[AW], MB, FS[4], MD, RW}, MSB first.
REQ-007 CTRVALID  input  1  CTRWRD is valid and is issued this cycle.
REQ-008 Cin  input  WIDTH  constant operand, selected onto bus B when MB=1.
REQ-009 Din  input  WIDTH  external data, written back when MD=1.
REQ-010 Dout  output  WIDTH  registered bus B (after the MB mux) of the op in stage 1.
REQ-011 Adrout  output  WIDTH  registered bus A of the op in stage 1.
REQ-012 WBVALID  output  1  one-cycle pulse: an op completed execute/writeback on the last edge.
REQ-013 V, C, N, Z  output  1 each  registered status flags of the last completed op with MD=0.

Function
REQ-014 Pipeline depth SHALL be 2 stages: issue/operand-fetch at edge k, then execute/writeback at edge k+1.
REQ-015 At edge k with CTRVALID=1, the block SHALL capture A=R[AA], B=(MB ? Cin : R[BA]), DA, FS, MD and RW, and SHALL set the stage-1 valid bit.
REQ-016 At edge k with CTRVALID=0, the stage-1 valid bit SHALL clear; Adrout and Dout SHALL hold.
REQ-017 At edge k+1, for a valid stage-1 op, the block SHALL compute F from FS and sample Din; the writeback value is W = MD ? Din : F.
REQ-018 At edge k+1, if RW=1, the block SHALL write R[DA] <= W; WBVALID SHALL be 1 during the following cycle only.
REQ-019 FS encoding: 0 A; 1 A+1; 2 A+B; 3 A+B+1; 4 A+~B; 5 A+~B+1; 6 A-1; 7 A; 8 A&B; 9 A|B; A A^B; B ~A; C B; D B>>1 (logical); E B<<1; F zero.
REQ-020 Arithmetic (FS 0-7): C = carry-out of the WIDTH-bit add; V = signed overflow. FS 6 SHALL be computed as A + all-ones.
REQ-021 Logic ops and FS C/F SHALL set C=0 and V=0. FS D SHALL set C=B[0]; FS E SHALL set C=B[WIDTH-1]; both SHALL set V=0.
REQ-022 N = F[WIDTH-1] and Z = (F==0); the flags SHALL update only at execute of a valid op with MD=0, and SHALL otherwise hold.
REQ-023 Results SHALL wrap modulo 2^WIDTH; no saturation.
REQ-024 Back-to-back issue every cycle SHALL be supported; throughput is 1 op per cycle.
REQ-025 The register-file write and the operand read of the same register on the same edge SHALL resolve per REQ-032/033.

Reset
REQ-026 RESET=1 SHALL asynchronously clear R[0..REGS-1], both pipeline stages, Dout, Adrout, WBVALID, V, C, N and Z to 0.
REQ-027 An op in flight when RESET asserts SHALL be discarded with no register write and no WBVALID.
REQ-028 The first edge after RESET deasserts SHALL issue normally if CTRVALID=1.

Configuration
REQ-029 Macro DATAPATH_PIPE_FWD_EN SHALL control operand forwarding.
REQ-030 Defined: when the executing op has RW=1 and DA==AA (or DA==BA with MB=0), the captured operand SHALL be that op's W.
REQ-031 Undefined: operands SHALL be read from the register file before the same-edge write, so a dependent back-to-back op sees the old value.
REQ-032 REQ-030 SHALL apply to A and B independently; forwarding SHALL NOT alter B when MB=1.
REQ-033 Forwarding SHALL never take data from a stage-1 op whose valid bit is 0.

Verification (WIDTH=16, REGS=8)
REQ-034 Reset, then load via MD=1: Din=0x1234 to R1 -> after 2 edges R1=0x1234, WBVALID pulses once, flags stay 0.
REQ-035 R1=0x7FFF, R2=0x0001, FS=2, DA=3 -> R3=0x8000, V=1, N=1, C=0, Z=0.
REQ-036 R1=0x0005, MB=1, Cin=0x0005, FS=5 -> F=0x0000, Z=1, C=1, V=0.
REQ-037 Back-to-back R3<=R1+1 then R4<=R3+1 with R1=0x0010 -> R4=0x0012 with FWD_EN defined; R4=old R3+1 without it.
REQ-038 R2=0x8001, FS=D, DA=5 -> R5=0x4000 and C=1; then FS=E with B=0x8001 -> 0x0002 and C=1.
REQ-039 RESET asserted between issue and execute of a write to R6 -> R6 stays 0, no WBVALID, flags 0.
